cmp_arbiter: RTL and testbench
==============================

# cmp_arbiter

Shares one 32-bit set-less-than/equality comparator between two requesters: port 0 is the branch-resolution path and port 1 is the ALU slt/sltu path. Round-robin arbitration and valid/ready handshakes pick one request at a time. The block registers the operands' signed or unsigned comparison and holds the result until the consumer accepts it. It sits between the decode/branch logic and the write-back mux.

## Interface
- WIDTH, 32, operand width in bits (≥ 2).
- PRIO_RESET, 0, port that holds priority after reset (0 or 1).

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_a, req0_b  in  WIDTH  port 0 operands.
- req0_signed  in  1  1 = two's-complement compare, 0 = unsigned.
- req1_valid, req1_ready, req1_a, req1_b, req1_signed: same as port 0, for port 1.
- rsp_valid  out  1  result held and valid.
- rsp_ready  in  1  consumer takes the result.
- rsp_id  out  1  port that issued the held result.
- rsp_result  out  WIDTH  {WIDTH-1 zeros, less}.
- rsp_equal  out  1  a == b.
- rsp_less  out  1  a < b under the selected signedness.

## Operation
- States:
  - IDLE: no held result.
  - HOLD: a result is held on the rsp_* outputs.
- Accept condition: `can_accept = (state == IDLE) || (state == HOLD && rsp_ready)`.
- Grant:
  - If only one port is valid, grant that port.
  - If both are valid, grant the port named by the priority pointer `prio`.
  - If neither is valid, no grant.
- req*_ready: reqN_ready = can_accept && grant == N, combinational from state, rsp_ready, the valids and prio. A port that is not granted sees ready = 0.
- Transfer: a request transfers on a cycle with valid && ready. On that clock edge:
  - Evaluate the granted operands.
  - Register rsp_less, rsp_equal, rsp_result and rsp_id.
  - Go to HOLD.
  - Set prio to the other port (1 − grant).
- Non-granted requests are not touched; prio does not change when there is no transfer.
- HOLD behaviour:
  - While rsp_ready = 0, the rsp_* outputs stay stable.
  - If rsp_ready = 1 and no transfer happens, go to IDLE and drop rsp_valid.
  - If rsp_ready = 1 and a new transfer happens in the same cycle, stay in HOLD with the new result (back-to-back, no bubble).
- Compare rules:
  - Unsigned: less = a < b on WIDTH bits.
  - Signed: if sign bits differ, less = a[WIDTH-1]. Otherwise less = the unsigned compare of the remaining bits.
  - equal = (a == b), independent of signedness.
- Requesters must keep valid, operands and signed stable until ready. The block does not check this.

## Timing
- Reset (rst_n low, asynchronous):
  - state = IDLE, rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_equal = 0, rsp_less = 0, prio = PRIO_RESET.
  - Both req*_ready read 0 while rst_n is low.
- Reset mid-operation discards any held result without delivering it. The first grant after reset follows PRIO_RESET.
- Latency: 1 cycle. A request accepted at edge k shows rsp_valid = 1 after edge k.
- Throughput: 1 result per cycle while rsp_ready stays high.
- Under continuous contention the ports strictly alternate. Neither port ever waits for more than one grant to the other port.
- Simultaneous rsp_ready and a new request in HOLD: the old result is consumed and the new one is registered on the same edge.

## Test plan
- Signedness, port 0 alone:
  - signed = 1, a = 0xFFFFFFFF, b = 0x00000001 → after 1 cycle rsp_valid = 1, rsp_id = 0, rsp_less = 1, rsp_result = 0x00000001, rsp_equal = 0.
  - Same operands with signed = 0 → rsp_less = 0, rsp_result = 0.
- Equality and sign boundary:
  - a = b = 0x80000000, signed = 1 → rsp_equal = 1, rsp_less = 0.
  - a = 0x80000000, b = 0x7FFFFFFF, signed = 1 → rsp_less = 1.
  - Same pair with signed = 0 → rsp_less = 0.
- Contention after reset with PRIO_RESET = 0: both ports valid continuously, rsp_ready = 1 → grants ordered 0, 1, 0, 1.
  - rsp_valid stays high every cycle from the first result onward.
  - rsp_id alternates 0, 1, 0, 1.
- Backpressure:
  - Hold rsp_ready = 0 for 3 cycles with both ports valid → rsp_* stay constant, both req*_ready = 0.
  - Release rsp_ready → the next port in round-robin order is accepted on the same edge.
- Reset mid-HOLD:
  - Assert rst_n = 0 between edges while rsp_valid = 1 → rsp_valid drops immediately and all rsp_* read 0.
  - After release, both ports valid → port PRIO_RESET is granted first.
- Idle drain: single request, rsp_ready = 1 on the cycle after it → the block returns to IDLE, rsp_valid = 0 on the next cycle, and prio points to the other port.

Source files
------------

// File: rtl/cmp_arbiter.sv
// Two-port round-robin arbiter in front of one shared signed/unsigned comparator.
// The granted operands are compared and the result is held until the consumer accepts it.
module cmp_arbiter #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned PRIO_RESET = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_signed,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_signed,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_equal,
    output logic             rsp_less
);

    localparam logic PRIO_INIT = 1'(PRIO_RESET);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic             prio_q, prio_d;
    logic             id_q, id_d;
    logic             less_q, less_d;
    logic             equal_q, equal_d;

    logic             can_accept;
    logic             grant;
    logic             xfer;
    logic [WIDTH-1:0] op_a, op_b;
    logic             op_signed;
    logic             cmp_less, cmp_equal;

    // With equal sign bits a full unsigned compare orders the remaining bits correctly.
    function automatic logic set_less(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                      input logic sgn);
        if (sgn && (a[WIDTH-1] != b[WIDTH-1])) begin
            return a[WIDTH-1];
        end
        return a < b;
    endfunction

    // Arbitration, handshake and operand selection.
    always_comb begin
        can_accept = (state_q == ST_IDLE) || rsp_ready;
        grant      = (req0_valid && req1_valid) ? prio_q : req1_valid;
        req0_ready = rst_n && can_accept && req0_valid && !grant;
        req1_ready = rst_n && can_accept && req1_valid && grant;
        xfer       = req0_ready || req1_ready;
        op_a       = grant ? req1_a : req0_a;
        op_b       = grant ? req1_b : req0_b;
        op_signed  = grant ? req1_signed : req0_signed;
        cmp_less   = set_less(op_a, op_b, op_signed);
        cmp_equal  = (op_a == op_b);
    end

    // Next state and held result.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        id_d    = id_q;
        less_d  = less_q;
        equal_d = equal_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (xfer)           state_d = ST_HOLD;
                else if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (xfer) begin
            id_d    = grant;
            less_d  = cmp_less;
            equal_d = cmp_equal;
            prio_d  = !grant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            prio_q  <= PRIO_INIT;
            id_q    <= 1'b0;
            less_q  <= 1'b0;
            equal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            id_q    <= id_d;
            less_q  <= less_d;
            equal_q <= equal_d;
        end
    end

    assign rsp_valid  = (state_q == ST_HOLD);
    assign rsp_id     = id_q;
    assign rsp_less   = less_q;
    assign rsp_equal  = equal_q;
    assign rsp_result = WIDTH'(less_q);

endmodule

// File: tb/tb_cmp_arbiter.sv
// Randomized bench for cmp_arbiter: a queue-free behavioural model predicts grants and
// compare results each cycle; directed sequences pin the model with literal values.
module tb_cmp_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_signed;
    logic        req1_valid, req1_ready, req1_signed;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_equal, rsp_less;
    logic [31:0] rsp_result;

    int tests = 0;
    int fails = 0;

    // Model state.
    bit m_valid, m_id, m_less, m_eq, m_prio;
    bit acc0, acc1;

    cmp_arbiter #(.WIDTH(32), .PRIO_RESET(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_signed(req0_signed),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_signed(req1_signed),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_equal(rsp_equal), .rsp_less(rsp_less)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic exp_ready(input int p);
        logic mine;
        mine = (p == 0) ? req0_valid : req1_valid;
        if (!rst_n || !mine) return 1'b0;
        if (m_valid && !rsp_ready) return 1'b0;
        if (req0_valid && req1_valid) return m_prio == p[0];
        return 1'b1;
    endfunction

    // Behavioural model: grants by rule, compare by native signed/unsigned arithmetic.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 0; m_id = 0; m_less = 0; m_eq = 0; m_prio = 0; acc0 = 0; acc1 = 0;
        end else begin
            logic [31:0] a, b;
            logic s;
            acc0 = exp_ready(0);
            acc1 = exp_ready(1);
            if (acc0 || acc1) begin
                a = acc1 ? req1_a : req0_a;
                b = acc1 ? req1_b : req0_b;
                s = acc1 ? req1_signed : req0_signed;
                m_eq    = (a == b);
                m_less  = s ? ($signed(a) < $signed(b)) : (a < b);
                m_id    = acc1;
                m_prio  = !acc1;
                m_valid = 1;
            end else if (rsp_ready) begin
                m_valid = 0;
            end
        end
    end

    // Per-cycle comparison against the model, well after inputs settle.
    always @(negedge clk) begin
        #3;
        chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        chk("req0_ready", 32'(req0_ready), 32'(exp_ready(0)));
        chk("req1_ready", 32'(req1_ready), 32'(exp_ready(1)));
        if (!rst_n || m_valid) begin
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
            chk("rsp_less", 32'(rsp_less), 32'(m_less));
            chk("rsp_equal", 32'(rsp_equal), 32'(m_eq));
            chk("rsp_result", rsp_result, 32'(m_less));
        end
    end

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic after_edge();
        @(posedge clk); #1;
    endtask

    task automatic set_req(input int p, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic s);
        if (p == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_signed = s;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_signed = s;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h0000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic sign_case(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic s, input logic less, input logic eq);
        step();
        set_req(0, 1, a, b, s);
        set_req(1, 0, 0, 0, 0);
        rsp_ready = 1;
        after_edge();
        chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({name, "_id"}, 32'(rsp_id), 32'd0);
        chk({name, "_less"}, 32'(rsp_less), 32'(less));
        chk({name, "_equal"}, 32'(rsp_equal), 32'(eq));
        chk({name, "_result"}, rsp_result, 32'(less));
    endtask

    initial begin
        rst_n = 0;
        rsp_ready = 0;
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1 chk("reset_ready0", 32'(req0_ready), 32'd0);
        chk("reset_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1;

        sign_case("s_neg1_lt_1", 32'hFFFF_FFFF, 32'h0000_0001, 1, 1, 0);
        sign_case("u_max_lt_1", 32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 0);
        sign_case("s_eq_min", 32'h8000_0000, 32'h8000_0000, 1, 0, 1);
        sign_case("s_min_lt_max", 32'h8000_0000, 32'h7FFF_FFFF, 1, 1, 0);
        sign_case("u_min_lt_max", 32'h8000_0000, 32'h7FFF_FFFF, 0, 0, 0);

        // Reset while a result is held.
        step();
        set_req(0, 1, 32'd5, 32'd5, 0);
        rsp_ready = 0;
        after_edge();
        chk("hold_valid", 32'(rsp_valid), 32'd1);
        step();
        set_req(0, 1, 32'd1, 32'd2, 0);
        set_req(1, 1, 32'd3, 32'd2, 0);
        #1 rst_n = 0;
        #1;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_equal", 32'(rsp_equal), 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);

        // Contention after reset alternates starting at port 0.
        step();
        rst_n = 1;
        rsp_ready = 1;
        for (int k = 0; k < 4; k++) begin
            after_edge();
            chk("cont_valid", 32'(rsp_valid), 32'd1);
            chk("cont_id", 32'(rsp_id), 32'(k % 2));
        end

        // Backpressure freezes the held result and blocks both ports.
        step();
        rsp_ready = 0;
        for (int k = 0; k < 3; k++) begin
            after_edge();
            chk("bp_ready0", 32'(req0_ready), 32'd0);
            chk("bp_ready1", 32'(req1_ready), 32'd0);
            chk("bp_id", 32'(rsp_id), 32'd1);
            chk("bp_less", 32'(rsp_less), 32'd0);
        end
        step();
        rsp_ready = 1;
        #1 chk("bp_rel_ready0", 32'(req0_ready), 32'd1);
        chk("bp_rel_ready1", 32'(req1_ready), 32'd0);
        after_edge();
        chk("bp_rel_id", 32'(rsp_id), 32'd0);

        // Idle drain leaves prio on the other port.
        step();
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        after_edge();
        chk("drain_valid", 32'(rsp_valid), 32'd0);
        step();
        set_req(0, 1, 32'd9, 32'd4, 0);
        rsp_ready = 0;
        after_edge();
        chk("single_id", 32'(rsp_id), 32'd0);
        step();
        set_req(0, 0, 0, 0, 0);
        rsp_ready = 1;
        after_edge();
        chk("single_drain", 32'(rsp_valid), 32'd0);
        step();
        set_req(0, 1, 32'd1, 32'd1, 0);
        set_req(1, 1, 32'd1, 32'd7, 0);
        after_edge();
        chk("prio_after_drain", 32'(rsp_id), 32'd1);
        chk("prio_after_less", 32'(rsp_less), 32'd1);
        step();
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);

        // Random traffic; requesters hold until accepted.
        for (int i = 0; i < 3000; i++) begin
            step();
            if (!req0_valid || acc0)
                set_req(0, $urandom_range(0, 99) < 60, pick(), pick(), 1'($urandom_range(0, 1)));
            if (req0_valid && acc0 && $urandom_range(0, 3) == 0) req0_b = req0_a;
            if (!req1_valid || acc1)
                set_req(1, $urandom_range(0, 99) < 60, pick(), pick(), 1'($urandom_range(0, 1)));
            if (req1_valid && acc1 && $urandom_range(0, 3) == 0) req1_b = req1_a;
            rsp_ready = $urandom_range(0, 99) < 70;
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 0;
                #1 rst_n = 1;
            end
        end

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
